udp_packet_sender: RTL and testbench

//  Ethernet TX framer for the eth path. Each i_sync rising edge emits one IPv4/UDP frame: header words, then payload streamed from the in-port.
//  The RX port sinks the incoming frame stream and answers ARP requests for SELF_IP with an ARP reply on the same TX port.

---
 rtl/udp_packet_sender.sv | 180 ++++++++++++++++++
 tb/tb_udp_packet_sender.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_packet_sender.sv
// udp_packet_sender: IPv4/UDP TX framer on a 32-bit word stream with an ARP responder on the RX side
module udp_packet_sender #(
    parameter logic [47:0] SELF_MAC = 48'h002236EC0401,
    parameter logic [31:0] SELF_IP  = 32'h0A000014,
    parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
    parameter logic [31:0] DST_IP   = 32'h0A000016,
    parameter logic [15:0] SRC_PORT = 16'h1122,
    parameter logic [15:0] DST_PORT = 16'h5152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sync,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_sop,
    input  logic        i_rx_eop,
    input  logic        i_rx_vld,
    output logic        o_rx_rdy,
    input  logic [31:0] i_in_data,
    input  logic        i_in_vld,
    output logic        o_in_rdy,
    input  logic [15:0] i_udp_pkt_len,
    output logic [31:0] o_tx_data,
    output logic        o_tx_sop,
    output logic        o_tx_eop,
    output logic        o_tx_vld,
    input  logic        i_tx_rdy
);
    typedef enum logic [2:0] {IDLE, PREP, HDR, PAY, ARP} state_t;
    state_t state;
    logic [3:0]  idx, rx_idx, rx_cur;
    logic [15:0] len, len_in, tot_len, tot_len_in, udp_len, ip_id, csum;
    logic [13:0] pay_left;
    logic        sync_d, udp_pend, arp_pend, rx_ok, rx_ok_now, word_ok, arp_hit, hdr;
    logic [47:0] cap_sha, sha;
    logic [31:0] cap_spa, spa, word;
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    assign len_in     = {i_udp_pkt_len[15:2], 2'b00};
    assign tot_len_in = 16'd28 + len_in;
    assign tot_len    = 16'd28 + len;
    assign udp_len    = 16'd8 + len;
    // Checksum field counts as zero; the result is latched in PREP together with the length.
    assign sum   = 20'h04500 + {4'h0, tot_len_in} + {4'h0, ip_id} + 20'h04000 + 20'h04011
                 + {4'h0, SELF_IP[31:16]} + {4'h0, SELF_IP[15:0]} + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
    assign fold1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    assign fold2 = fold1[15:0] + {15'h0, fold1[16]};

    // RX word index restarts at sop; every ARP-relevant word must match for the frame to count.
    assign rx_cur    = i_rx_sop ? 4'd0 : rx_idx;
    assign word_ok   = rx_cur == 4'd3  ? i_rx_data[15:0] == 16'h0806 :
                       rx_cur == 4'd4  ? i_rx_data == 32'h00010800 :
                       rx_cur == 4'd5  ? i_rx_data == 32'h06040001 :
                       rx_cur == 4'd10 ? i_rx_data == SELF_IP : 1'b1;
    assign rx_ok_now = (i_rx_sop || rx_ok) && word_ok;
    // A request arriving while a reply is being sent is dropped so the reply fields stay intact.
    assign arp_hit   = i_rx_vld && i_rx_eop && rx_ok_now && rx_cur >= 4'd10 && state != ARP;

    assign hdr       = state == HDR || state == ARP;
    assign o_tx_vld  = state == PAY ? i_in_vld : hdr;
    assign o_tx_data = state == PAY ? i_in_data : hdr ? word : '0;
    assign o_tx_sop  = hdr && idx == 4'd0;
    assign o_tx_eop  = (hdr && idx == 4'd10 && (state == ARP || len == 16'd0)) || (state == PAY && pay_left == 14'd1);
    assign o_in_rdy  = state == PAY && i_tx_rdy;
    assign o_rx_rdy  = ~rst;

    // Header word table for the frame currently being sent.
    always_comb begin
        word = '0;
        if (state == ARP)
            case (idx)
                4'd0:    word = {16'h0000, sha[47:32]};
                4'd1:    word = sha[31:0];
                4'd2:    word = SELF_MAC[47:16];
                4'd3:    word = {SELF_MAC[15:0], 16'h0806};
                4'd4:    word = 32'h00010800;
                4'd5:    word = 32'h06040002;
                4'd6:    word = SELF_MAC[47:16];
                4'd7:    word = {SELF_MAC[15:0], SELF_IP[31:16]};
                4'd8:    word = {SELF_IP[15:0], sha[47:32]};
                4'd9:    word = sha[31:0];
                4'd10:   word = spa;
                default: word = '0;
            endcase
        else
            case (idx)
                4'd0:    word = {16'h0000, DST_MAC[47:32]};
                4'd1:    word = DST_MAC[31:0];
                4'd2:    word = SELF_MAC[47:16];
                4'd3:    word = {SELF_MAC[15:0], 16'h0800};
                4'd4:    word = {16'h4500, tot_len};
                4'd5:    word = {ip_id, 16'h4000};
                4'd6:    word = {16'h4011, csum};
                4'd7:    word = SELF_IP;
                4'd8:    word = DST_IP;
                4'd9:    word = {SRC_PORT, DST_PORT};
                4'd10:   word = {udp_len, 16'h0000};
                default: word = '0;
            endcase
    end

    // RX parser: track word index, capture sender fields, and latch them on a matching request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_idx  <= '0;
            rx_ok   <= 1'b0;
            cap_sha <= '0;
            cap_spa <= '0;
            sha     <= '0;
            spa     <= '0;
        end else if (i_rx_vld) begin
            rx_idx <= rx_cur == 4'd15 ? rx_cur : rx_cur + 4'd1;
            rx_ok  <= rx_ok_now && !i_rx_eop;
            if (rx_cur == 4'd6) cap_sha[47:16] <= i_rx_data;
            if (rx_cur == 4'd7) {cap_sha[15:0], cap_spa[31:16]} <= i_rx_data;
            if (rx_cur == 4'd8) cap_spa[15:0] <= i_rx_data[31:16];
            if (arp_hit) begin
                sha <= cap_sha;
                spa <= cap_spa;
            end
        end
    end

    // TX sequencer: trigger detection, ARP-first arbitration and word stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            len      <= '0;
            ip_id    <= '0;
            csum     <= '0;
            pay_left <= '0;
            sync_d   <= 1'b0;
            udp_pend <= 1'b0;
            arp_pend <= 1'b0;
        end else begin
            sync_d <= i_sync;
            if (i_sync && !sync_d)
                udp_pend <= 1'b1;
            else if (state == IDLE && !arp_pend && udp_pend)
                udp_pend <= 1'b0;
            if (arp_hit)
                arp_pend <= 1'b1;
            else if (state == IDLE)
                arp_pend <= 1'b0;
            case (state)
                IDLE: begin
                    idx   <= '0;
                    state <= arp_pend ? ARP : udp_pend ? PREP : IDLE;
                end
                PREP: begin
                    len      <= len_in;
                    csum     <= ~fold2;
                    pay_left <= len_in[15:2];
                    state    <= HDR;
                end
                HDR: if (i_tx_rdy) begin
                    idx <= idx == 4'd10 ? 4'd0 : idx + 4'd1;
                    if (idx == 4'd10) begin
                        state <= len == 16'd0 ? IDLE : PAY;
                        if (len == 16'd0) ip_id <= ip_id + 16'd1;
                    end
                end
                PAY: if (i_in_vld && i_tx_rdy) begin
                    pay_left <= pay_left - 14'd1;
                    if (pay_left == 14'd1) begin
                        state <= IDLE;
                        ip_id <= ip_id + 16'd1;
                    end
                end
                ARP: if (i_tx_rdy) begin
                    idx   <= idx == 4'd10 ? 4'd0 : idx + 4'd1;
                    state <= idx == 4'd10 ? IDLE : ARP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_packet_sender.sv
// tb_udp_packet_sender: directed scenarios for the UDP framer and ARP responder
module tb_udp_packet_sender;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_sync;
    logic [31:0] i_rx_data;
    logic        i_rx_sop, i_rx_eop, i_rx_vld, o_rx_rdy;
    logic [31:0] i_in_data;
    logic        i_in_vld, o_in_rdy;
    logic [15:0] i_udp_pkt_len;
    logic [31:0] o_tx_data;
    logic        o_tx_sop, o_tx_eop, o_tx_vld, i_tx_rdy;

    int errors = 0;
    int checks = 0;
    int nw, in_acc, stall_err;
    bit done;
    logic [31:0] cap_data [0:1023];
    logic        cap_sop  [0:1023];
    logic        cap_eop  [0:1023];

    udp_packet_sender dut (
        .clk(clk), .rst(rst), .i_sync(i_sync),
        .i_rx_data(i_rx_data), .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop), .i_rx_vld(i_rx_vld), .o_rx_rdy(o_rx_rdy),
        .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy), .i_udp_pkt_len(i_udp_pkt_len),
        .o_tx_data(o_tx_data), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop), .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_sync();
        @(posedge clk); #1;
        i_sync = 1'b1;
        @(posedge clk); #1;
        i_sync = 1'b0;
    endtask

    // Collects one TX frame (stops at EOP or after max_cyc cycles); tog enables back-pressure patterns.
    task automatic run_frame(input int max_cyc, input bit tog);
        bit acc, pst;
        logic [31:0] pw;
        acc = 1'b0; pst = 1'b0; pw = '0;
        nw = 0; in_acc = 0; stall_err = 0; done = 1'b0;
        i_in_data = 32'hA0000000;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(posedge clk); #1;
            if (acc) i_in_data = i_in_data + 32'd1;
            i_tx_rdy = tog ? (c % 3 != 1) : 1'b1;
            i_in_vld = tog ? (c % 5 != 2) : 1'b1;
            @(negedge clk);
            if (pst && o_tx_vld && o_tx_data !== pw) stall_err++;
            pst = o_tx_vld && !i_tx_rdy;
            pw  = o_tx_data;
            acc = o_in_rdy && i_in_vld;
            if (acc) in_acc++;
            if (o_tx_vld && i_tx_rdy) begin
                if (nw < 1024) begin
                    cap_data[nw] = o_tx_data;
                    cap_sop[nw]  = o_tx_sop;
                    cap_eop[nw]  = o_tx_eop;
                end
                nw++;
                if (o_tx_eop) done = 1'b1;
            end
        end
        @(posedge clk); #1;
        i_tx_rdy = 1'b0;
        i_in_vld = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] tpa);
        logic [31:0] w [0:10];
        w = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h3CF011B2, 32'h523C0806, 32'h00010800, 32'h06040001,
              32'h3CF011B2, 32'h523CC0A8, 32'h012E0000, 32'h00000000, tpa};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            i_rx_vld  = 1'b1;
            i_rx_sop  = (i == 0);
            i_rx_eop  = (i == 10);
            i_rx_data = w[i];
        end
        @(posedge clk); #1;
        i_rx_vld = 1'b0; i_rx_sop = 1'b0; i_rx_eop = 1'b0;
    endtask

    task automatic check_payload(input string name, input int n);
        int bad;
        bad = 0;
        for (int j = 0; j < n; j++)
            if (cap_data[11 + j] !== 32'hA0000000 + j) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d payload words differ from the accepted sequence", name, bad);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_tx_vld, o_tx_sop, o_tx_eop, o_in_rdy, o_rx_rdy} !== 5'b0 || o_tx_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got vld/sop/eop/in_rdy/rx_rdy=%b data=%h, expected all 0",
                     {o_tx_vld, o_tx_sop, o_tx_eop, o_in_rdy, o_rx_rdy}, o_tx_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_rx_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy: got %b expected 1", o_rx_rdy); end
        checks++;
        if (o_tx_vld !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b expected 0", o_tx_vld); end
    endtask

    task automatic test_udp_frame();
        logic [31:0] e [0:10];
        int neop, nsop;
        e = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h002236EC, 32'h04010800, 32'h4500081C, 32'h00004000,
              32'h40111EA8, 32'h0A000014, 32'h0A000016, 32'h11225152, 32'h08080000};
        i_udp_pkt_len = 16'd2048;
        pulse_sync();
        run_frame(700, 1'b0);
        checks++;
        if (nw !== 523 || !done) begin errors++; $display("FAIL udp_len: got %0d words done=%0b expected 523", nw, done); end
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (cap_data[k] !== e[k]) begin errors++; $display("FAIL udp_w%0d: got %h expected %h", k, cap_data[k], e[k]); end
        end
        checks++;
        if (in_acc !== 512) begin errors++; $display("FAIL udp_in_rdy: got %0d accepts expected 512", in_acc); end
        neop = 0; nsop = 0;
        for (int k = 0; k < 523; k++) begin neop += int'(cap_eop[k]); nsop += int'(cap_sop[k]); end
        checks++;
        if (cap_eop[522] !== 1'b1 || neop !== 1) begin errors++; $display("FAIL udp_eop: last=%b count=%0d expected 1/1", cap_eop[522], neop); end
        checks++;
        if (cap_sop[0] !== 1'b1 || nsop !== 1) begin errors++; $display("FAIL udp_sop: first=%b count=%0d expected 1/1", cap_sop[0], nsop); end
        check_payload("udp_payload", 512);
    endtask

    task automatic test_checksum();
        int unsigned s;
        i_udp_pkt_len = 16'd8;
        pulse_sync();
        run_frame(60, 1'b0);
        checks++;
        if (nw !== 13) begin errors++; $display("FAIL csum_len: got %0d words expected 13", nw); end
        s = 0;
        for (int k = 4; k <= 8; k++) s += 32'(cap_data[k][31:16]) + 32'(cap_data[k][15:0]);
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        checks++;
        if (s !== 32'hFFFF) begin errors++; $display("FAIL csum_sum: got %h expected 0000ffff", s); end
        checks++;
        if (cap_data[5] !== 32'h00014000) begin errors++; $display("FAIL ip_id_inc: got %h expected 00014000", cap_data[5]); end
        checks++;
        if (cap_data[4] !== 32'h45000024) begin errors++; $display("FAIL csum_w4: got %h expected 45000024", cap_data[4]); end
        i_udp_pkt_len = 16'd3;
        pulse_sync();
        run_frame(60, 1'b0);
        checks++;
        if (nw !== 11 || cap_eop[10] !== 1'b1 || in_acc !== 0) begin
            errors++;
            $display("FAIL zero_len: got %0d words eop10=%b accepts=%0d expected 11/1/0", nw, cap_eop[10], in_acc);
        end
        checks++;
        if (cap_data[10] !== 32'h00080000 || cap_data[5] !== 32'h00024000) begin
            errors++;
            $display("FAIL zero_len_hdr: got w10=%h w5=%h expected 00080000/00024000", cap_data[10], cap_data[5]);
        end
    endtask

    task automatic test_arp();
        logic [31:0] e [0:10];
        e = '{32'h00003CF0, 32'h11B2523C, 32'h002236EC, 32'h04010806, 32'h00010800, 32'h06040002,
              32'h002236EC, 32'h04010A00, 32'h00143CF0, 32'h11B2523C, 32'hC0A8012E};
        send_rx(32'h0A000014);
        run_frame(60, 1'b0);
        checks++;
        if (nw !== 11 || cap_eop[10] !== 1'b1 || cap_sop[0] !== 1'b1) begin
            errors++;
            $display("FAIL arp_len: got %0d words sop=%b eop=%b expected 11/1/1", nw, cap_sop[0], cap_eop[10]);
        end
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (cap_data[k] !== e[k]) begin errors++; $display("FAIL arp_w%0d: got %h expected %h", k, cap_data[k], e[k]); end
        end
        send_rx(32'h0A000015);
        run_frame(40, 1'b0);
        checks++;
        if (nw !== 0) begin errors++; $display("FAIL arp_other_ip: got %0d TX words expected 0", nw); end
    endtask

    task automatic test_backpressure();
        i_udp_pkt_len = 16'd64;
        pulse_sync();
        run_frame(300, 1'b1);
        checks++;
        if (nw !== 27 || !done) begin errors++; $display("FAIL bp_len: got %0d words done=%0b expected 27", nw, done); end
        checks++;
        if (in_acc !== 16) begin errors++; $display("FAIL bp_in_rdy: got %0d accepts expected 16", in_acc); end
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: %0d stalled words changed, expected 0", stall_err); end
        checks++;
        if (cap_data[5] !== 32'h00034000 || cap_data[6][31:16] !== 16'h4011) begin
            errors++;
            $display("FAIL bp_hdr: got w5=%h w6=%h expected 00034000/4011xxxx", cap_data[5], cap_data[6]);
        end
        check_payload("bp_payload", 16);
    endtask

    task automatic test_back_to_back();
        i_udp_pkt_len = 16'd8;
        send_rx(32'h0A000014);
        pulse_sync();
        pulse_sync();
        run_frame(60, 1'b0);
        checks++;
        if (nw !== 11 || cap_data[5] !== 32'h06040002) begin
            errors++;
            $display("FAIL b2b_arp: got %0d words w5=%h expected 11/06040002", nw, cap_data[5]);
        end
        run_frame(60, 1'b0);
        checks++;
        if (nw !== 13 || cap_data[5] !== 32'h00044000 || cap_sop[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_udp: got %0d words w5=%h expected 13/00044000", nw, cap_data[5]);
        end
        run_frame(60, 1'b0);
        checks++;
        if (nw !== 0) begin errors++; $display("FAIL b2b_extra: got %0d extra TX words expected 0", nw); end
    endtask

    task automatic test_reset_mid();
        i_udp_pkt_len = 16'd2048;
        pulse_sync();
        i_tx_rdy = 1'b1;
        i_in_vld = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (o_in_rdy !== 1'b1) begin errors++; $display("FAIL mid_pay: got in_rdy=%b expected 1", o_in_rdy); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o_tx_vld, o_tx_sop, o_tx_eop, o_in_rdy} !== 4'b0 || o_tx_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got vld/sop/eop/in_rdy=%b data=%h expected 0",
                     {o_tx_vld, o_tx_sop, o_tx_eop, o_in_rdy}, o_tx_data);
        end
        rst = 1'b0;
        i_tx_rdy = 1'b0;
        i_in_vld = 1'b0;
        i_udp_pkt_len = 16'd8;
        pulse_sync();
        run_frame(60, 1'b0);
        checks++;
        if (nw !== 13 || cap_eop[12] !== 1'b1 || cap_data[5] !== 32'h00004000) begin
            errors++;
            $display("FAIL post_reset: got %0d words eop=%b w5=%h expected 13/1/00004000", nw, cap_eop[12], cap_data[5]);
        end
    endtask

    initial begin
        rst = 1'b1; i_sync = 1'b0;
        i_rx_data = '0; i_rx_sop = 1'b0; i_rx_eop = 1'b0; i_rx_vld = 1'b0;
        i_in_data = '0; i_in_vld = 1'b0; i_udp_pkt_len = '0; i_tx_rdy = 1'b0;
        test_reset();
        test_udp_frame();
        test_checksum();
        test_arp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
